// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants and the decoded control bundle carried down the pipeline.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [2:0] aluop;
    logic       branch;
    logic [1:0] jaltype;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // JAL and LUI carry no register source in the rs1 field
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_JAL || op == OP_LUI);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R_TYPE) || (op == OP_SW) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detection: a load sitting in EX whose destination feeds the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       load_use_o
);

  logic match_rs1;
  logic match_rs2;

  assign match_rs1  = uses_rs1(id_opcode_i) && (ex_rd_i == id_rs1_i);
  assign match_rs2  = uses_rs2(id_opcode_i) && (ex_rd_i == id_rs2_i);
  assign load_use_o = ex_valid_i && ex_memread_i && (ex_rd_i != 5'd0) && id_valid_i
                      && (match_rs1 || match_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream freeze.
// Optional bubble counter enabled by defining ID_EX_PERF_EN.
module id_ex_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [2:0]        id_aluop,
  input  logic [1:0]        id_jaltype,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [2:0]        ex_aluop,
  output logic [1:0]        ex_jaltype,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_valid,
  output logic              stall_if_id
`ifdef ID_EX_PERF_EN
  ,output logic [15:0]      bubble_cnt
`endif
);

  ctrl_t              ctrl_d, ctrl_q, ctrl_in;
  logic               valid_d, valid_q;
  logic [4:0]         rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [2:0]         funct3_d, funct3_q;
  logic [6:0]         funct7_d, funct7_q;
  logic [PC_W-1:0]    pc_d, pc_q;
  logic [DATA_W-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic               load_use;
  logic               bubble;

  hazard_detect u_hazard (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q.memread),
    .ex_rd_i      (rd_q),
    .id_valid_i   (id_valid),
    .id_opcode_i  (id_opcode),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .load_use_o   (load_use)
  );

  assign ctrl_in = '{alusrc: id_alusrc, memtoreg: id_memtoreg, regwrite: id_regwrite,
                     memread: id_memread, memwrite: id_memwrite, aluop: id_aluop,
                     branch: id_branch, jaltype: id_jaltype};

  assign bubble      = ex_flush || load_use;
  // A flushed ID instruction is on the wrong path, so it is dropped rather than held
  assign stall_if_id = mem_stall || (load_use && !ex_flush);

  always_comb begin
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    pc_d     = pc_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    if (!mem_stall) begin
      if (bubble || !id_valid) begin
        ctrl_d   = CTRL_NOP;
        valid_d  = 1'b0;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        funct3_d = '0;
        funct7_d = '0;
        pc_d     = '0;
        rd1_d    = '0;
        rd2_d    = '0;
        imm_d    = '0;
      end else begin
        ctrl_d   = ctrl_in;
        valid_d  = 1'b1;
        rs1_d    = id_rs1;
        rs2_d    = id_rs2;
        rd_d     = id_rd;
        funct3_d = id_funct3;
        funct7_d = id_funct7;
        pc_d     = id_pc;
        rd1_d    = id_rd1;
        rd2_d    = id_rd2;
        imm_d    = id_imm;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_NOP;
      valid_q  <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      pc_q     <= pc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [15:0] bubble_cnt_q;

  // Frozen edges are not bubbles, and the count saturates instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (!mem_stall && bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_jaltype  = ctrl_q.jaltype;
  assign ex_valid    = valid_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct3   = funct3_q;
  assign ex_funct7   = funct7_q;
  assign ex_pc       = pc_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_imm      = imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a model.
module tb_id_ex_stage;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        alusrc;
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [2:0]  aluop;
    logic        branch;
    logic [1:0]  jaltype;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } slot_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ex_flush = 1'b0;
  logic mem_stall = 1'b0;
  logic [6:0] id_op = 7'd0;
  slot_t id_s = '0;
  slot_t model = '0;
  slot_t got;
  int model_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic last_stall;

  logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_valid, stall_if_id;
  logic [2:0] ex_aluop, ex_funct3;
  logic [1:0] ex_jaltype;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [6:0] ex_funct7;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
`ifdef ID_EX_PERF_EN
  logic [15:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_s.valid), .id_opcode(id_op),
    .id_alusrc(id_s.alusrc), .id_memtoreg(id_s.memtoreg), .id_regwrite(id_s.regwrite),
    .id_memread(id_s.memread), .id_memwrite(id_s.memwrite), .id_branch(id_s.branch),
    .id_aluop(id_s.aluop), .id_jaltype(id_s.jaltype), .id_rs1(id_s.rs1), .id_rs2(id_s.rs2),
    .id_rd(id_s.rd), .id_funct3(id_s.f3), .id_funct7(id_s.f7), .id_pc(id_s.pc),
    .id_rd1(id_s.rd1), .id_rd2(id_s.rd2), .id_imm(id_s.imm),
    .ex_flush(ex_flush), .mem_stall(mem_stall),
    .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_jaltype(ex_jaltype), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_pc(ex_pc),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_valid(ex_valid),
    .stall_if_id(stall_if_id)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  assign got = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                ex_aluop, ex_branch, ex_jaltype, ex_rs1, ex_rs2, ex_rd, ex_funct3,
                ex_funct7, ex_pc, ex_rd1, ex_rd2, ex_imm};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic chk_ex(input string tag);
    chk({tag, "_valid"}, 128'(got.valid), 128'(model.valid));
    chk({tag, "_ctrl"}, 128'(got[163:153]), 128'(model[163:153]));
    chk({tag, "_idx"}, 128'(got[152:128]), 128'(model[152:128]));
    chk({tag, "_data"}, got[127:0], model[127:0]);
`ifdef ID_EX_PERF_EN
    chk({tag, "_bcnt"}, 128'(bubble_cnt), 128'(model_cnt));
`endif
  endtask

  // A load in EX blocks the ID instruction if it reads the load's destination
  function automatic logic hazard(input slot_t e, input slot_t d, input logic [6:0] op);
    logic reads_a;
    logic reads_b;
    reads_a = (op != OP_JAL) && (op != OP_LUI);
    reads_b = (op == OP_R_TYPE) || (op == OP_SW) || (op == OP_BR);
    return e.valid && e.memread && (e.rd != 0) && d.valid &&
           ((reads_a && e.rd == d.rs1) || (reads_b && e.rd == d.rs2));
  endfunction

  task automatic cycle();
    logic hz;
    logic exp_stall;
    slot_t nxt;
    @(negedge clk);
    hz = hazard(model, id_s, id_op);
    exp_stall = mem_stall || (hz && !ex_flush);
    last_stall = stall_if_id;
    chk("stall_if_id", 128'(stall_if_id), 128'(exp_stall));
    if (mem_stall) nxt = model;
    else if (ex_flush || hz) begin
      nxt = '0;
      if (model_cnt < 65535) model_cnt++;
    end else if (id_s.valid) nxt = id_s;
    else nxt = '0;
    @(posedge clk);
    #1;
    model = nxt;
    cyc++;
    chk_ex("ex");
    $display("cyc %0d op=%b v=%0d rs=%0d,%0d rd=%0d flush=%0d mstall=%0d stall=%0d -> ex_valid=%0d ex_rd=%0d",
             cyc, id_op, id_s.valid, id_s.rs1, id_s.rs2, id_s.rd, ex_flush, mem_stall,
             last_stall, ex_valid, ex_rd);
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic regw, input logic memr,
                        input logic memw, input logic [2:0] aluop);
    id_op = op;
    id_s = '0;
    id_s.valid = 1'b1;
    id_s.rs1 = rs1;
    id_s.rs2 = rs2;
    id_s.rd = rd;
    id_s.regwrite = regw;
    id_s.memread = memr;
    id_s.memtoreg = memr;
    id_s.memwrite = memw;
    id_s.alusrc = memr | memw;
    id_s.aluop = aluop;
    id_s.pc = $urandom;
    id_s.rd1 = $urandom;
    id_s.rd2 = $urandom;
    id_s.imm = $urandom;
  endtask

  task automatic rand_id();
    logic [6:0] ops [8];
    ops = '{OP_LW, OP_SW, OP_R_TYPE, OP_I_TYPE, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    id_op = ops[$urandom_range(0, 7)];
    id_s.valid = ($urandom_range(0, 7) != 0);
    {id_s.alusrc, id_s.memtoreg, id_s.regwrite, id_s.memwrite, id_s.aluop,
     id_s.branch, id_s.jaltype} = 10'($urandom);
    id_s.memread = (id_op == OP_LW);
    id_s.rs1 = 5'($urandom_range(0, 3));
    id_s.rs2 = 5'($urandom_range(0, 3));
    id_s.rd = 5'($urandom_range(0, 3));
    id_s.f3 = 3'($urandom);
    id_s.f7 = 7'($urandom);
    id_s.pc = $urandom;
    id_s.rd1 = $urandom;
    id_s.rd2 = $urandom;
    id_s.imm = $urandom;
  endtask

  initial begin
    #1;
    chk("rst_ex", 128'(got[164:128]), 128'(0));
    chk("rst_data", got[127:0], 128'(0));
    #20 reset = 1'b0;

    // ADD x3,x1,x2
    set_id(OP_R_TYPE, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'b010);
    cycle();
    chk("add_regwrite", 128'(ex_regwrite), 128'(1));
    chk("add_aluop", 128'(ex_aluop), 128'(3'b010));
    chk("add_rd", 128'(ex_rd), 128'(3));
    chk("add_valid", 128'(ex_valid), 128'(1));

    // LW x5 then ADD x6,x5,x1: one bubble, then the held ADD loads
    set_id(OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle();
    set_id(OP_R_TYPE, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 3'b010);
    cycle();
    chk("lu_stall", 128'(last_stall), 128'(1));
    chk("lu_bubble", 128'(ex_valid), 128'(0));
    cycle();
    chk("lu_release", 128'(last_stall), 128'(0));
    chk("lu_load_rd", 128'(ex_rd), 128'(6));

    // LW x0 followed by a reader of x0
    set_id(OP_LW, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle();
    set_id(OP_R_TYPE, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b010);
    cycle();
    chk("x0_no_stall", 128'(last_stall), 128'(0));

    // LW x5 followed by LUI x5
    set_id(OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle();
    set_id(OP_LUI, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    cycle();
    chk("lui_no_stall", 128'(last_stall), 128'(0));

    // Flush beats load-use
    set_id(OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle();
    set_id(OP_SW, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    ex_flush = 1'b1;
    cycle();
    chk("flush_stall", 128'(last_stall), 128'(0));
    chk("flush_memwrite", 128'(ex_memwrite), 128'(0));
    chk("flush_valid", 128'(ex_valid), 128'(0));

    // mem_stall for 3 cycles with flush pending, then bubble
    ex_flush = 1'b0;
    set_id(OP_I_TYPE, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b011);
    cycle();
    ex_flush = 1'b1;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mstall_hold_rd", 128'(ex_rd), 128'(9));
    end
    mem_stall = 1'b0;
    cycle();
    chk("mstall_then_bubble", 128'(ex_valid), 128'(0));
    ex_flush = 1'b0;

    // Random traffic; ID is held while the stage asks IF/ID to stall
    for (int i = 0; i < 300; i++) begin
      if (!last_stall) rand_id();
      ex_flush = ($urandom_range(0, 6) == 0);
      mem_stall = ($urandom_range(0, 6) == 0);
      cycle();
    end

    // Asynchronous reset mid-cycle with state loaded and a stall pending
    ex_flush = 1'b0;
    mem_stall = 1'b0;
    set_id(OP_R_TYPE, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 3'b010);
    cycle();
    mem_stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    model = '0;
    model_cnt = 0;
    chk_ex("rst_mid");
    #4 reset = 1'b0;
    mem_stall = 1'b0;
    cycle();
    chk("post_rst_valid", 128'(ex_valid), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
